// File: rtl/peak_readout_serializer.sv
`default_nettype none
// ============================================================================
// Module  : peak_readout_serializer
// Purpose : Shadows one frame of per-pixel peak words and streams it out on a
//           valid/ready link tagged with pixel index and frame number.
//           Optional build macro PEAK_ZERO_SKIP_EN suppresses zero words.
// Revision: 1.0 - initial release
// ============================================================================
module peak_readout_serializer #(
  parameter int NP      = 10,
  parameter int NPIX    = 16,
  parameter int IDX_W   = (NPIX > 1) ? $clog2(NPIX) : 1,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               res,
  input  logic               peakValid,
  input  logic [NP-1:0]      peakIn [NPIX-1:0],
  output logic               outValid,
  input  logic               outReady,
  output logic [NP-1:0]      outData,
  output logic [IDX_W-1:0]   outIdx,
  output logic [FRAME_W-1:0] outFrame,
  output logic               outLast,
  output logic               busy,
  output logic               frameDone,
  output logic [7:0]         overrunCnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               r_state, w_state_n;
  logic [NP-1:0]        r_shadow [NPIX-1:0];
  logic [IDX_W-1:0]     r_idx, w_idx_n;
  logic [NP-1:0]        r_data, w_data_n;
  logic                 r_last, w_last_n;
  logic [FRAME_W-1:0]   r_frameCnt, w_frameCnt_n;
  logic [FRAME_W-1:0]   r_outFrame, w_outFrame_n;
  logic [7:0]           r_ovr, w_ovr_n;
  logic                 r_done, w_done_n;

  logic [NPIX-1:0]      w_keep_in, w_keep_sh;
  logic [IDX_W:0]       w_first, w_adv;
  logic                 w_first_more, w_adv_more;
  logic                 w_fire, w_final, w_accept, w_drop;

  // Lowest kept index at or above start; MSB flags that one was found.
  function automatic logic [IDX_W:0] f_find(input logic [NPIX-1:0] mask, input int start);
    logic [IDX_W:0] v_res;
    v_res = '0;
    for (int i = NPIX - 1; i >= 0; i--) begin
      if (i >= start && mask[i]) v_res = {1'b1, IDX_W'(i)};
    end
    return v_res;
  endfunction

  function automatic logic f_any(input logic [NPIX-1:0] mask, input int start);
    logic v_any;
    v_any = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      if (i >= start && mask[i]) v_any = 1'b1;
    end
    return v_any;
  endfunction

  always_comb begin
    for (int i = 0; i < NPIX; i++) begin
`ifdef PEAK_ZERO_SKIP_EN
      w_keep_in[i] = |peakIn[i];
      w_keep_sh[i] = |r_shadow[i];
`else
      w_keep_in[i] = 1'b1;
      w_keep_sh[i] = 1'b1;
`endif
    end
  end

  assign w_first      = f_find(w_keep_in, 0);
  assign w_first_more = f_any(w_keep_in, int'(w_first[IDX_W-1:0]) + 1);
  assign w_adv        = f_find(w_keep_sh, int'(r_idx) + 1);
  assign w_adv_more   = f_any(w_keep_sh, int'(w_adv[IDX_W-1:0]) + 1);

  assign w_fire   = (r_state == SEND) && outReady;
  assign w_final  = w_fire && r_last;
  assign w_accept = peakValid && ((r_state == IDLE) || w_final);
  assign w_drop   = peakValid && (r_state == SEND) && !w_final;

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_data_n     = r_data;
    w_last_n     = r_last;
    w_frameCnt_n = r_frameCnt;
    w_outFrame_n = r_outFrame;
    w_ovr_n      = r_ovr;
    w_done_n     = 1'b0;

    if (w_final) begin
      w_state_n    = IDLE;
      w_idx_n      = '0;
      w_data_n     = '0;
      w_last_n     = 1'b0;
      w_outFrame_n = '0;
      w_frameCnt_n = r_frameCnt + FRAME_W'(1);
      w_done_n     = 1'b1;
    end else if (w_fire) begin
      w_idx_n  = w_adv[IDX_W-1:0];
      w_data_n = r_shadow[w_adv[IDX_W-1:0]];
      w_last_n = !w_adv_more;
    end

    if (w_drop && (r_ovr != 8'hFF)) w_ovr_n = r_ovr + 8'd1;

    // A capture with nothing to emit retires immediately as an empty frame.
    if (w_accept) begin
      if (w_first[IDX_W]) begin
        w_state_n    = SEND;
        w_idx_n      = w_first[IDX_W-1:0];
        w_data_n     = peakIn[w_first[IDX_W-1:0]];
        w_last_n     = !w_first_more;
        w_outFrame_n = w_frameCnt_n;
      end else begin
        w_frameCnt_n = w_frameCnt_n + FRAME_W'(1);
        w_done_n     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_frameCnt <= '0;
      r_outFrame <= '0;
      r_ovr      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_data     <= w_data_n;
      r_last     <= w_last_n;
      r_frameCnt <= w_frameCnt_n;
      r_outFrame <= w_outFrame_n;
      r_ovr      <= w_ovr_n;
      r_done     <= w_done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (res && w_accept) r_shadow <= peakIn;
  end

  assign outValid   = (r_state == SEND);
  assign busy       = (r_state == SEND);
  assign outData    = r_data;
  assign outIdx     = r_idx;
  assign outFrame   = r_outFrame;
  assign outLast    = r_last;
  assign frameDone  = r_done;
  assign overrunCnt = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_peak_readout_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_peak_readout_serializer
// Purpose : Randomised self-checking bench for peak_readout_serializer with a
//           frame-level reference model (honours PEAK_ZERO_SKIP_EN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_peak_readout_serializer;

  localparam int NP      = 10;
  localparam int NPIX    = 3;
  localparam int IDX_W   = 2;
  localparam int FRAME_W = 8;

  logic               clk = 1'b0;
  logic               res = 1'b0;
  logic               peakValid = 1'b0;
  logic               outReady = 1'b0;
  logic [NP-1:0]      peakIn [NPIX-1:0];
  logic               outValid, outLast, busy, frameDone;
  logic [NP-1:0]      outData;
  logic [IDX_W-1:0]   outIdx;
  logic [FRAME_W-1:0] outFrame;
  logic [7:0]         overrunCnt;

  typedef struct {
    logic [NP-1:0]    d;
    logic [IDX_W-1:0] idx;
    logic             last;
  } word_t;

  word_t         exp_q [$];
  logic [NP-1:0] frm [NPIX-1:0];
  int            checks = 0;
  int            errors = 0;
  int            m_frame = 0;
  int            m_ovr = 0;

  peak_readout_serializer #(.NP(NP), .NPIX(NPIX), .IDX_W(IDX_W), .FRAME_W(FRAME_W)) dut (
    .clk(clk), .res(res), .peakValid(peakValid), .peakIn(peakIn),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outIdx(outIdx),
    .outFrame(outFrame), .outLast(outLast), .busy(busy), .frameDone(frameDone),
    .overrunCnt(overrunCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic make_frame(input bit allow_zero);
    for (int i = 0; i < NPIX; i++)
      frm[i] = (allow_zero && $urandom_range(0, 2) == 0) ? '0 : NP'($urandom_range(1, 1023));
  endtask

  // Expected word list: every pixel in order, or only nonzero ones when skipping.
  function automatic void load_frame();
    int hi;
    bit keep [NPIX];
    exp_q.delete();
    hi = -1;
    for (int i = 0; i < NPIX; i++) begin
`ifdef PEAK_ZERO_SKIP_EN
      keep[i] = (frm[i] != 0);
`else
      keep[i] = 1'b1;
`endif
      if (keep[i]) hi = i;
    end
    for (int i = 0; i < NPIX; i++)
      if (keep[i]) exp_q.push_back('{d: frm[i], idx: IDX_W'(i), last: (i == hi)});
  endfunction

  task automatic capture();
    peakIn = frm;
    peakValid = 1'b1;
    @(negedge clk);
    peakValid = 1'b0;
    load_frame();
  endtask

  task automatic test_reset();
    res = 1'b0;
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({outValid, outLast, frameDone, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: v=%b last=%b done=%b busy=%b, expected all 0", outValid, outLast, frameDone, busy);
    end
    checks++;
    if (outData !== '0 || outIdx !== '0 || outFrame !== '0) begin
      errors++;
      $display("FAIL reset_data: d=%0d idx=%0d fr=%0d, expected 0 0 0", outData, outIdx, outFrame);
    end
    checks++;
    if (overrunCnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_overrun: got %0d expected 0", overrunCnt);
    end
    res = 1'b1;
    m_frame = 0;
    m_ovr = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    frm[0] = 10'd108; frm[1] = 10'd0; frm[2] = 10'd300;
    outReady = 1'b1;
    capture();
    for (int g = 0; g < 10 && exp_q.size() > 0; g++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx ||
          outFrame !== m_frame[7:0] || outLast !== exp_q[0].last) begin
        errors++;
        $display("FAIL basic_word: v=%b d=%0d idx=%0d fr=%0d last=%b, expected d=%0d idx=%0d fr=%0d last=%b",
                 outValid, outData, outIdx, outFrame, outLast, exp_q[0].d, exp_q[0].idx, m_frame[7:0], exp_q[0].last);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++;
    if (frameDone !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b v=%b busy=%b, expected 1 0 0", frameDone, outValid, busy);
    end
    m_frame++;
    @(negedge clk);
    checks++;
    if (frameDone !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b expected 0", frameDone);
    end
  endtask

  task automatic test_backpressure();
    frm[0] = 10'd108; frm[1] = 10'd0; frm[2] = 10'd300;
    outReady = 1'b1;
    capture();
    void'(exp_q.pop_front());
    @(negedge clk);
    outReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx || outLast !== exp_q[0].last) begin
        errors++;
        $display("FAIL bp_hold: v=%b d=%0d idx=%0d last=%b, expected d=%0d idx=%0d last=%b",
                 outValid, outData, outIdx, outLast, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
      end
      @(negedge clk);
    end
    outReady = 1'b1;
    for (int g = 0; g < 10 && exp_q.size() > 0; g++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx ||
          outFrame !== m_frame[7:0] || outLast !== exp_q[0].last) begin
        errors++;
        $display("FAIL bp_word: v=%b d=%0d idx=%0d fr=%0d last=%b, expected d=%0d idx=%0d fr=%0d last=%b",
                 outValid, outData, outIdx, outFrame, outLast, exp_q[0].d, exp_q[0].idx, m_frame[7:0], exp_q[0].last);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++;
    if (frameDone !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: done=%b expected 1", frameDone);
    end
    m_frame++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      outReady = 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      make_frame(1'b1);
      capture();
      for (int g = 0; g < 200 && exp_q.size() > 0; g++) begin
        outReady = $urandom_range(0, 1);
        checks++;
        if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx ||
            outFrame !== m_frame[7:0] || outLast !== exp_q[0].last) begin
          errors++;
          $display("FAIL rand_word: v=%b d=%0d idx=%0d fr=%0d last=%b, expected d=%0d idx=%0d fr=%0d last=%b",
                   outValid, outData, outIdx, outFrame, outLast, exp_q[0].d, exp_q[0].idx, m_frame[7:0], exp_q[0].last);
        end
        if (outReady) void'(exp_q.pop_front());
        @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0 || frameDone !== 1'b1 || outValid !== 1'b0) begin
        errors++;
        $display("FAIL rand_done: left=%0d done=%b v=%b, expected 0 1 0", exp_q.size(), frameDone, outValid);
      end
      m_frame++;
    end
    outReady = 1'b1;
  endtask

  task automatic test_overrun();
    make_frame(1'b0);
    outReady = 1'b1;
    capture();
    void'(exp_q.pop_front());
    for (int i = 0; i < NPIX; i++) peakIn[i] = NP'($urandom_range(1, 1023));
    peakValid = 1'b1;
    @(negedge clk);
    peakValid = 1'b0;
    m_ovr++;
    checks++;
    if (overrunCnt !== 8'(m_ovr)) begin
      errors++;
      $display("FAIL ovr_count: got %0d expected %0d", overrunCnt, m_ovr);
    end
    for (int g = 0; g < 10 && exp_q.size() > 0; g++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx || outLast !== exp_q[0].last) begin
        errors++;
        $display("FAIL ovr_word: v=%b d=%0d idx=%0d last=%b, expected d=%0d idx=%0d last=%b",
                 outValid, outData, outIdx, outLast, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    m_frame++;

    // Saturation: park in SEND and strobe peakValid every cycle.
    make_frame(1'b0);
    capture();
    outReady = 1'b0;
    for (int i = 0; i < NPIX; i++) peakIn[i] = NP'($urandom_range(1, 1023));
    peakValid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
      checks++;
      if (overrunCnt !== 8'(m_ovr)) begin
        errors++;
        $display("FAIL ovr_sat: step %0d got %0d expected %0d", k, overrunCnt, m_ovr);
      end
    end
    peakValid = 1'b0;
    outReady = 1'b1;
    for (int g = 0; g < 10 && exp_q.size() > 0; g++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx || outFrame !== m_frame[7:0]) begin
        errors++;
        $display("FAIL ovr_sat_word: v=%b d=%0d idx=%0d fr=%0d, expected d=%0d idx=%0d fr=%0d",
                 outValid, outData, outIdx, outFrame, exp_q[0].d, exp_q[0].idx, m_frame[7:0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    m_frame++;
  endtask

  task automatic test_back_to_back();
    make_frame(1'b0);
    outReady = 1'b1;
    capture();
    make_frame(1'b0);
    for (int g = 0; g < 10 && exp_q.size() > 0; g++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx || outLast !== exp_q[0].last) begin
        errors++;
        $display("FAIL b2b_word: v=%b d=%0d idx=%0d last=%b, expected d=%0d idx=%0d last=%b",
                 outValid, outData, outIdx, outLast, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
      end
      if (exp_q.size() == 1) begin
        peakIn = frm;
        peakValid = 1'b1;
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    peakValid = 1'b0;
    m_frame++;
    load_frame();
    checks++;
    if (frameDone !== 1'b1 || outValid !== 1'b1 || outFrame !== m_frame[7:0] ||
        outIdx !== exp_q[0].idx || outData !== exp_q[0].d || overrunCnt !== 8'(m_ovr)) begin
      errors++;
      $display("FAIL b2b_handover: done=%b v=%b fr=%0d idx=%0d d=%0d ovr=%0d, expected 1 1 %0d %0d %0d %0d",
               frameDone, outValid, outFrame, outIdx, outData, overrunCnt,
               m_frame[7:0], exp_q[0].idx, exp_q[0].d, m_ovr);
    end
    for (int g = 0; g < 10 && exp_q.size() > 0; g++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx || outFrame !== m_frame[7:0]) begin
        errors++;
        $display("FAIL b2b_second: v=%b d=%0d idx=%0d fr=%0d, expected d=%0d idx=%0d fr=%0d",
                 outValid, outData, outIdx, outFrame, exp_q[0].d, exp_q[0].idx, m_frame[7:0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    m_frame++;
  endtask

  task automatic test_mid_reset();
    make_frame(1'b0);
    outReady = 1'b1;
    capture();
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++;
    if (outIdx !== 2'd1 || outValid !== 1'b1) begin
      errors++;
      $display("FAIL mrst_pre: idx=%0d v=%b, expected 1 1", outIdx, outValid);
    end
    res = 1'b0;
    @(negedge clk);
    res = 1'b1;
    m_frame = 0;
    m_ovr = 0;
    checks++;
    if (outValid !== 1'b0 || frameDone !== 1'b0 || busy !== 1'b0 || overrunCnt !== 8'd0) begin
      errors++;
      $display("FAIL mrst_state: v=%b done=%b busy=%b ovr=%0d, expected 0 0 0 0", outValid, frameDone, busy, overrunCnt);
    end
    @(negedge clk);
    make_frame(1'b0);
    capture();
    for (int g = 0; g < 10 && exp_q.size() > 0; g++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0].d || outIdx !== exp_q[0].idx || outFrame !== m_frame[7:0]) begin
        errors++;
        $display("FAIL mrst_word: v=%b d=%0d idx=%0d fr=%0d, expected d=%0d idx=%0d fr=%0d",
                 outValid, outData, outIdx, outFrame, exp_q[0].d, exp_q[0].idx, m_frame[7:0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++;
    if (frameDone !== 1'b1) begin
      errors++;
      $display("FAIL mrst_done: done=%b expected 1", frameDone);
    end
    m_frame++;
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) peakIn[i] = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
